flag_register_stack: RTL
========================

// Module: flag_register_stack
// PURPOSE
//   Parametrised processor status/flag register with a shadow save stack.
//   Holds NFLAGS condition flags (bit0=C, bit1=Z, bit2=N, bit3=V by default).
//   Flags are updated per bit from the ALU, or set/cleared by instruction decode.
//   PUSH/POP save and restore the whole flag word on interrupt entry and return.
// PARAMETERS
//   NFLAGS    4      number of flag bits (>=1)
//   DEPTH     4      shadow stack entries (>=1)
//   RESET_VAL 0      NFLAGS-bit reset value of the live flag word
// PORTS
//   clk        in   1              rising-edge clock
//   rst_n      in   1              asynchronous, active-low reset
//   flag_in    in   NFLAGS         ALU-produced flag values
//   load_mask  in   NFLAGS         per-bit load enable: flags[i] <= flag_in[i]
//   set_mask   in   NFLAGS         per-bit set request
//   clr_mask   in   NFLAGS         per-bit clear request
//   push       in   1              save live flag word onto the stack
//   pop        in   1              restore live flag word from the stack top
//   err_clr    in   1              clear sticky error
//   flags      out  NFLAGS         live flag word (registered)
//   level      out  $clog2(DEPTH+1) stack occupancy, 0..DEPTH
//   full       out  1              level == DEPTH
//   empty      out  1              level == 0
//   err        out  1              sticky stack misuse flag
// BEHAVIOUR
//   Reset (rst_n=0, async): flags=RESET_VAL, level=0, err=0. Stack contents are don't-care.
//   All state changes on the rising clk edge. Outputs are registered, so an update is visible 1 cycle later.
//   Per-bit update with no valid pop: load_mask[i] > set_mask[i] > clr_mask[i] > hold.
//     Bits are independent: a set on one bit never blocks a set/clr/load on another.
//   Valid push (push=1, pop=0, !full): stack[level] <= flags as seen BEFORE this edge;
//     level+1. Same-cycle load/set/clr still update the live word.
//   Valid pop (pop=1, push=0, !empty): flags <= stack[level-1]; level-1.
//     All load/set/clr masks are ignored that cycle; pop wins over every bit.
//   Push while full: stack and level unchanged; err<=1. Live updates apply normally.
//   Pop while empty: no restore, level stays 0; err<=1. Live updates apply normally.
//   push and pop in the same cycle: illegal. Neither is performed and err<=1. Live updates apply.
//   err is sticky until err_clr=1. If err_clr is asserted in the same cycle as a new error, the new error wins and err=1.
//   full/empty are decoded combinationally from the registered level. They never glitch across a clock edge.
//   Stack is LIFO: level counts 0..DEPTH with no wrap-around. Counter width is $clog2(DEPTH+1).
//   Reset asserted mid-operation: everything returns to reset values immediately; any pending push/pop is lost.
//   No combinational path from any input to flags, level or err.
// TESTING (NFLAGS=4, DEPTH=2, RESET_VAL=0)
//   Reset, then load_mask=4'b0011, flag_in=4'b1111 -> flags=4'b0011 next cycle.
//     Then set_mask=4'b1000 with clr_mask=4'b0001 -> flags=4'b1010.
//   Per-bit priority: load_mask=4'b0001, flag_in=0, set_mask=4'b0011 -> bit0=0, bit1=1.
//     clr_mask=set_mask=4'b0100 -> bit2=1.
//   flags=4'b0101: push; next cycle push with flags=4'b1010; then third push -> level=2, full=1, err=1.
//     Then pop -> flags=4'b1010, level=1. Pop -> flags=4'b0101, level=0, empty=1.
//   Pop with empty and load_mask=4'b1111, flag_in=4'b0110 -> flags=4'b0110, level=0, err=1.
//     Then err_clr -> err=0.
//   Pop with set_mask=4'b1111 and level=1 -> flags equal the saved word, not 4'b1111.
//     push+pop together -> level unchanged, err=1.
//   Assert rst_n=0 asynchronously between edges with level=2 -> flags, level and err are 0 at once; empty=1.

Source files
------------

// File: rtl/flag_register_stack_if.sv
// Bus bundle for flag_register_stack.
// The master modport drives flag updates and stack commands; the slave modport returns state.
interface flag_register_stack_if #(
  parameter int NFLAGS = 4,
  parameter int DEPTH  = 4
);
  localparam int LW = $clog2(DEPTH + 1);

  logic [NFLAGS-1:0] flag_in;
  logic [NFLAGS-1:0] load_mask;
  logic [NFLAGS-1:0] set_mask;
  logic [NFLAGS-1:0] clr_mask;
  logic              push;
  logic              pop;
  logic              err_clr;
  logic [NFLAGS-1:0] flags;
  logic [LW-1:0]     level;
  logic              full;
  logic              empty;
  logic              err;

  modport master (
    output flag_in, load_mask, set_mask, clr_mask, push, pop, err_clr,
    input  flags, level, full, empty, err
  );

  modport slave (
    input  flag_in, load_mask, set_mask, clr_mask, push, pop, err_clr,
    output flags, level, full, empty, err
  );
endinterface

// File: rtl/flag_register_stack.sv
// Processor flag register with a LIFO shadow stack for interrupt save/restore.
// Live bits are updated per bit; a valid pop restores the whole word and overrides every bit.
module flag_register_stack #(
  parameter int                NFLAGS    = 4,
  parameter int                DEPTH     = 4,
  parameter logic [NFLAGS-1:0] RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  flag_register_stack_if.slave bus
);
  localparam int LW = $clog2(DEPTH + 1);

  logic [NFLAGS-1:0] flags_q;
  logic [NFLAGS-1:0] flags_d;
  logic [NFLAGS-1:0] stack_q [DEPTH];
  logic [NFLAGS-1:0] top;
  logic [LW-1:0]     level_q;
  logic              err_q;
  logic              full;
  logic              empty;
  logic              push_ok;
  logic              pop_ok;
  logic              misuse;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

  assign push_ok = bus.push && !bus.pop && !full;
  assign pop_ok  = bus.pop && !bus.push && !empty;
  assign misuse  = (bus.push && bus.pop) ||
                   (bus.push && !bus.pop && full) ||
                   (bus.pop && !bus.push && empty);

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (level_q == LW'(i + 1)) top = stack_q[i];
    end
  end

  // Per-bit priority: load > set > clear > hold, then a valid pop overrides the lot.
  always_comb begin
    flags_d = (bus.load_mask & bus.flag_in)
            | (~bus.load_mask & bus.set_mask)
            | (~bus.load_mask & ~bus.set_mask & ~bus.clr_mask & flags_q);
    if (pop_ok) flags_d = top;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= RESET_VAL;
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      if (push_ok)     level_q <= level_q + LW'(1);
      else if (pop_ok) level_q <= level_q - LW'(1);
      if (misuse)           err_q <= 1'b1;
      else if (bus.err_clr) err_q <= 1'b0;
    end
  end

  // Stack contents are don't-care after reset, so no reset term here.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push_ok && level_q == LW'(i)) stack_q[i] <= flags_q;
    end
  end

  assign bus.flags = flags_q;
  assign bus.level = level_q;
  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.err   = err_q;
endmodule
